// File: rtl/aes_package.sv
// Shared types for the AES stream engine: controller/engine handshake structs,
// engine state encoding and block geometry.
package aes_package;

    localparam int AES_CNT_W           = 16;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_LOAD,
        ENG_CORE_START,
        ENG_CORE_WAIT,
        ENG_DRAIN,
        ENG_DONE
    } aes_eng_state_t;

    typedef struct packed {
        logic                 enable;
        logic                 clear;
        logic                 start;
        logic [AES_CNT_W-1:0] n_blocks;
    } ctrl_engine_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic [AES_CNT_W-1:0] block_cnt;
    } flags_engine_t;

endpackage

// File: rtl/aes_word_unpacker.sv
// Holds one 128-bit ciphertext block and presents it as four 32-bit words,
// most significant word first, over a valid/ready stream.
module aes_word_unpacker
    import aes_package::*;
#(
    parameter int DW = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_clear,
    input  logic                              i_capture,
    input  logic [DW*AES_WORDS_PER_BLOCK-1:0] i_block,
    input  logic                              i_ready,
    output logic [DW-1:0]                     o_data,
    output logic                              o_valid,
    output logic                              o_last
);

    localparam int WC_W = $clog2(AES_WORDS_PER_BLOCK);

    logic [AES_WORDS_PER_BLOCK-1:0][DW-1:0] r_block;
    logic [WC_W-1:0]                        r_word_cnt;
    logic                                   r_valid;
    logic                                   w_hs;
    logic [WC_W-1:0]                        w_sel;

    assign w_hs    = r_valid & i_ready;
    assign o_last  = w_hs && (r_word_cnt == WC_W'(AES_WORDS_PER_BLOCK - 1));
    assign w_sel   = WC_W'(AES_WORDS_PER_BLOCK - 1) - r_word_cnt;
    assign o_data  = r_block[w_sel];
    assign o_valid = r_valid;

    // Valid and data only change on capture, handshake or clear, so they hold while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_block    <= '0;
            r_word_cnt <= '0;
            r_valid    <= 1'b0;
        end else if (i_clear) begin
            r_block    <= '0;
            r_word_cnt <= '0;
            r_valid    <= 1'b0;
        end else if (i_capture) begin
            r_block    <= i_block;
            r_word_cnt <= '0;
            r_valid    <= 1'b1;
        end else if (w_hs) begin
            r_word_cnt <= r_word_cnt + WC_W'(1);
            if (o_last) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_stream_engine.sv
// AES HWPE engine: packs the 32-bit plaintext stream into 128-bit blocks,
// runs each through the AES core and streams the ciphertext back out.
module aes_stream_engine
    import aes_package::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = AES_CNT_W
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  ctrl_engine_t                      ctrl_i,
    output flags_engine_t                     flags_o,
    input  logic [DW-1:0]                     pt_data_i,
    input  logic                              pt_valid_i,
    output logic                              pt_ready_o,
    output logic [DW-1:0]                     ct_data_o,
    output logic                              ct_valid_o,
    input  logic                              ct_ready_i,
    output logic                              core_start_o,
    output logic [DW*AES_WORDS_PER_BLOCK-1:0] core_block_o,
    input  logic                              core_done_i,
    input  logic [DW*AES_WORDS_PER_BLOCK-1:0] core_block_i
);

    localparam int WC_W = $clog2(AES_WORDS_PER_BLOCK);

    aes_eng_state_t                         r_state;
    aes_eng_state_t                         w_state_nxt;
    logic [AES_WORDS_PER_BLOCK-1:0][DW-1:0] r_pt_block;
    logic [WC_W-1:0]                        r_load_cnt;
    logic [CNT_W-1:0]                       r_n_blocks;
    logic [CNT_W-1:0]                       r_block_cnt;

    logic            w_clear;
    logic            w_start;
    logic            w_pt_hs;
    logic            w_load_last;
    logic            w_capture;
    logic            w_out_last;
    logic [WC_W-1:0] w_load_sel;
    logic [CNT_W-1:0] w_block_cnt_nxt;

    assign w_clear         = clear | ctrl_i.clear;
    assign w_start         = ctrl_i.start & ctrl_i.enable;
    assign w_pt_hs         = (r_state == ENG_LOAD) & pt_valid_i;
    assign w_load_last     = w_pt_hs && (r_load_cnt == WC_W'(AES_WORDS_PER_BLOCK - 1));
    assign w_load_sel      = WC_W'(AES_WORDS_PER_BLOCK - 1) - r_load_cnt;
    assign w_capture       = (r_state == ENG_CORE_WAIT) & core_done_i;
    assign w_block_cnt_nxt = r_block_cnt + CNT_W'(1);
    assign core_block_o    = r_pt_block;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ENG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output and the next state get a default before the case, so
    // no path through this block can leave a variable unassigned (no latches).
    always_comb begin
        w_state_nxt       = r_state;
        pt_ready_o        = 1'b0;
        core_start_o      = 1'b0;
        flags_o.busy      = (r_state != ENG_IDLE);
        flags_o.done      = 1'b0;
        flags_o.block_cnt = r_block_cnt;
        unique case (r_state)
            ENG_IDLE: begin
                if (w_start) begin
                    w_state_nxt = (ctrl_i.n_blocks == '0) ? ENG_DONE : ENG_LOAD;
                end
            end
            ENG_LOAD: begin
                pt_ready_o = 1'b1;
                if (w_load_last) w_state_nxt = ENG_CORE_START;
            end
            ENG_CORE_START: begin
                core_start_o = 1'b1;
                w_state_nxt  = ENG_CORE_WAIT;
            end
            ENG_CORE_WAIT: begin
                if (core_done_i) w_state_nxt = ENG_DRAIN;
            end
            ENG_DRAIN: begin
                if (w_out_last) begin
                    w_state_nxt = (w_block_cnt_nxt == r_n_blocks) ? ENG_DONE : ENG_LOAD;
                end
            end
            ENG_DONE: begin
                flags_o.done = 1'b1;
                w_state_nxt  = ENG_IDLE;
            end
            default: w_state_nxt = ENG_IDLE;
        endcase
        if (w_clear) w_state_nxt = ENG_IDLE;
    end

    // NOTE: the plaintext block register is reset and cleared like control state,
    // so core_block_o is a defined zero after reset and never leaks a discarded block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pt_block  <= '0;
            r_load_cnt  <= '0;
            r_n_blocks  <= '0;
            r_block_cnt <= '0;
        end else if (w_clear) begin
            r_pt_block  <= '0;
            r_load_cnt  <= '0;
            r_n_blocks  <= '0;
            r_block_cnt <= '0;
        end else begin
            unique case (r_state)
                ENG_IDLE: begin
                    if (w_start) begin
                        r_n_blocks  <= ctrl_i.n_blocks;
                        r_block_cnt <= '0;
                        r_load_cnt  <= '0;
                    end
                end
                ENG_LOAD: begin
                    if (w_pt_hs) begin
                        r_pt_block[w_load_sel] <= pt_data_i;
                        r_load_cnt             <= r_load_cnt + WC_W'(1);
                    end
                end
                ENG_DRAIN: begin
                    if (w_out_last) r_block_cnt <= w_block_cnt_nxt;
                end
                default: ;
            endcase
        end
    end

    aes_word_unpacker #(
        .DW(DW)
    ) u_unpacker (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_clear),
        .i_capture(w_capture),
        .i_block  (core_block_i),
        .i_ready  (ct_ready_i),
        .o_data   (ct_data_o),
        .o_valid  (ct_valid_o),
        .o_last   (w_out_last)
    );

endmodule

// File: tb/tb_aes_stream_engine.sv
// Directed bench for aes_stream_engine with a behavioural AES core that returns
// the FIPS-197 ciphertext for the FIPS-197 plaintext and the inverted block otherwise.
module tb_aes_stream_engine;
    import aes_package::*;

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    ctrl_engine_t  ctrl;
    flags_engine_t flags;
    logic [31:0]   pt_data;
    logic          pt_valid;
    logic          pt_ready;
    logic [31:0]   ct_data;
    logic          ct_valid;
    logic          ct_ready;
    logic          core_start;
    logic [127:0]  core_blk_out;
    logic [127:0]  core_blk_in;
    logic          core_done;
    logic          model_done;
    logic          tb_done;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    assign core_done = model_done | tb_done;

    aes_stream_engine #(.DW(32), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .ctrl_i      (ctrl),
        .flags_o     (flags),
        .pt_data_i   (pt_data),
        .pt_valid_i  (pt_valid),
        .pt_ready_o  (pt_ready),
        .ct_data_o   (ct_data),
        .ct_valid_o  (ct_valid),
        .ct_ready_i  (ct_ready),
        .core_start_o(core_start),
        .core_block_o(core_blk_out),
        .core_done_i (core_done),
        .core_block_i(core_blk_in)
    );

    function automatic logic [127:0] core_fn(input logic [127:0] b);
        return (b == FIPS_PT) ? FIPS_CT : ~b;
    endfunction

    // Core model: fixed 10-cycle latency from core_start to a one-cycle done.
    int           core_timer;
    logic [127:0] core_hold;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_timer  <= 0;
            model_done  <= 1'b0;
            core_blk_in <= '0;
            core_hold   <= '0;
        end else begin
            model_done <= 1'b0;
            if (core_start) begin
                core_hold  <= core_blk_out;
                core_timer <= 10;
            end else if (core_timer > 0) begin
                core_timer <= core_timer - 1;
                if (core_timer == 1) begin
                    model_done  <= 1'b1;
                    core_blk_in <= core_fn(core_hold);
                end
            end
        end
    end

    always @(negedge clk) if (reset_n && flags.done) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] n);
        ctrl.enable   = 1'b1;
        ctrl.start    = 1'b1;
        ctrl.n_blocks = n;
        tick();
        ctrl.start = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input int first, input int gap_pct,
                              output bit to);
        int budget;
        bit accepted;
        to = 1'b0;
        for (int i = first; i < 4; i++) begin
            budget   = 0;
            accepted = 1'b0;
            pt_data  = blk[127-32*i -: 32];
            while (!accepted) begin
                pt_valid = !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
                if (pt_valid && pt_ready) accepted = 1'b1;
                tick();
                budget++;
                if (budget > 200) begin
                    to       = 1'b1;
                    pt_valid = 1'b0;
                    return;
                end
            end
        end
        pt_valid = 1'b0;
    endtask

    task automatic recv_block(input int stall_pct, output logic [127:0] got, output bit to,
                              output bit stable_ok);
        int          budget;
        bit          taken;
        logic        v0;
        logic [31:0] d0;
        to        = 1'b0;
        stable_ok = 1'b1;
        got       = '0;
        for (int i = 0; i < 4; i++) begin
            budget = 0;
            taken  = 1'b0;
            while (!taken) begin
                ct_ready = ($urandom_range(0, 99) >= stall_pct);
                if (ct_valid && ct_ready) begin
                    got[127-32*i -: 32] = ct_data;
                    taken = 1'b1;
                    tick();
                end else begin
                    v0 = ct_valid;
                    d0 = ct_data;
                    tick();
                    if (v0 && (ct_valid !== 1'b1 || ct_data !== d0)) stable_ok = 1'b0;
                end
                budget++;
                if (budget > 300) begin
                    to       = 1'b1;
                    ct_ready = 1'b0;
                    return;
                end
            end
        end
        ct_ready = 1'b0;
    endtask

    task automatic wait_ct_valid(output bit to);
        int budget = 0;
        to = 1'b0;
        while (ct_valid !== 1'b1) begin
            tick();
            budget++;
            if (budget > 100) begin
                to = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (flags !== '0) begin n_fail++; $display("FAIL reset_flags: got %h want 0", flags); end
        n_tests++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pt_ready: got %b want 0", pt_ready); end
        n_tests++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ct_valid: got %b want 0", ct_valid); end
        n_tests++; if (ct_data !== 32'h0) begin n_fail++; $display("FAIL reset_ct_data: got %h want 0", ct_data); end
        n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start: got %b want 0", core_start); end
        n_tests++; if (core_blk_out !== 128'h0) begin n_fail++; $display("FAIL reset_core_block: got %h want 0", core_blk_out); end
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_block();
        bit           to;
        bit           st;
        int           budget;
        logic [127:0] got;
        start_job(16'd1);
        n_tests++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after_start: got %b want 1", pt_ready); end
        n_tests++; if (flags.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", flags.busy); end
        send_block(FIPS_PT, 0, 0, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_load_timeout: got %b want 0", to); end
        n_tests++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL single_core_start: got %b want 1", core_start); end
        n_tests++; if (core_blk_out !== FIPS_PT) begin n_fail++; $display("FAIL single_core_block: got %h want %h", core_blk_out, FIPS_PT); end
        tick();
        n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL single_core_start_pulse: got %b want 0", core_start); end
        budget = 0;
        while (core_done !== 1'b1 && budget < 100) begin tick(); budget++; end
        n_tests++; if (core_done !== 1'b1) begin n_fail++; $display("FAIL single_core_done_timeout: got %b want 1", core_done); end
        n_tests++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b want 0", ct_valid); end
        tick();
        n_tests++; if (ct_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_after_done: got %b want 1", ct_valid); end
        n_tests++; if (ct_data !== 32'h69c4e0d8) begin n_fail++; $display("FAIL single_first_word: got %h want 69c4e0d8", ct_data); end
        recv_block(0, got, to, st);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_drain_timeout: got %b want 0", to); end
        n_tests++; if (got !== FIPS_CT) begin n_fail++; $display("FAIL single_ct_words: got %h want %h", got, FIPS_CT); end
        n_tests++; if (flags.done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", flags.done); end
        n_tests++; if (flags.block_cnt !== 16'd1) begin n_fail++; $display("FAIL single_block_cnt: got %0d want 1", flags.block_cnt); end
        tick();
        n_tests++; if (flags.done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0", flags.done); end
        n_tests++; if (flags.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", flags.busy); end
        n_tests++; if (flags.block_cnt !== 16'd1) begin n_fail++; $display("FAIL single_block_cnt_hold: got %0d want 1", flags.block_cnt); end
    endtask

    task automatic test_backpressure();
        logic [127:0] blks [3];
        logic [127:0] got;
        bit           to;
        bit           st;
        int           d0;
        blks[0] = 128'h0123456789abcdeffedcba9876543210;
        blks[1] = 128'hdeadbeefcafef00d0badc0de12345678;
        blks[2] = 128'h55aa55aa00ff00ff13579bdf2468ace0;
        d0 = done_cnt;
        start_job(16'd3);
        for (int b = 0; b < 3; b++) begin
            send_block(blks[b], 0, 30, to);
            n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_load_timeout blk%0d: got %b want 0", b, to); end
            recv_block(50, got, to, st);
            n_tests++; if (got !== ~blks[b]) begin n_fail++; $display("FAIL bp_words blk%0d: got %h want %h", b, got, ~blks[b]); end
            n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable blk%0d: got %b want 1", b, st); end
        end
        n_tests++; if (flags.done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", flags.done); end
        n_tests++; if (flags.block_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_block_cnt: got %0d want 3", flags.block_cnt); end
        tick();
        tick();
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    // The start cycle is T; the job goes straight to ENG_DONE, the only busy cycle.
    task automatic test_zero_blocks();
        start_job(16'd0);
        n_tests++; if (flags.busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_t1: got %b want 1", flags.busy); end
        n_tests++; if (flags.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", flags.done); end
        n_tests++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL zero_pt_ready_t1: got %b want 0", pt_ready); end
        tick();
        n_tests++; if (flags.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_t2: got %b want 0", flags.busy); end
        n_tests++; if (flags.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 0", flags.done); end
        n_tests++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL zero_pt_ready_t2: got %b want 0", pt_ready); end
        n_tests++; if (flags.block_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_block_cnt: got %0d want 0", flags.block_cnt); end
    endtask

    task automatic test_clear();
        logic [127:0] blk = 128'hffeeddccbbaa99887766554433221100;
        bit           to;
        int           d0;
        d0 = done_cnt;
        start_job(16'd1);
        pt_valid = 1'b1;
        pt_data  = 32'h11111111;
        tick();
        pt_data  = 32'h22222222;
        tick();
        pt_valid = 1'b0;
        n_tests++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_before: got %b want 1", pt_ready); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_tests++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_drop: got %b want 0", pt_ready); end
        n_tests++; if (flags.busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b want 0", flags.busy); end
        n_tests++; if (core_blk_out !== 128'h0) begin n_fail++; $display("FAIL clr_block_zero: got %h want 0", core_blk_out); end
        ctrl.start    = 1'b1;
        ctrl.n_blocks = 16'd1;
        clear         = 1'b1;
        tick();
        ctrl.start = 1'b0;
        clear      = 1'b0;
        n_tests++; if (flags.busy !== 1'b0) begin n_fail++; $display("FAIL clr_beats_start: got %b want 0", flags.busy); end
        start_job(16'd1);
        send_block(blk, 0, 0, to);
        n_tests++; if (core_blk_out !== blk) begin n_fail++; $display("FAIL clr_new_job_block: got %h want %h", core_blk_out, blk); end
        wait_ct_valid(to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL clr_drain_timeout: got %b want 0", to); end
        ct_ready = 1'b1;
        tick();
        tick();
        ct_ready = 1'b0;
        n_tests++; if (ct_data !== ~blk[63:32]) begin n_fail++; $display("FAIL clr_third_word: got %h want %h", ct_data, ~blk[63:32]); end
        ctrl.clear = 1'b1;
        tick();
        ctrl.clear = 1'b0;
        n_tests++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid_drop: got %b want 0", ct_valid); end
        n_tests++; if (ct_data !== 32'h0) begin n_fail++; $display("FAIL clr_data_zero: got %h want 0", ct_data); end
        n_tests++; if (flags.block_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_block_cnt: got %0d want 0", flags.block_cnt); end
        tick();
        tick();
        n_tests++; if (done_cnt !== d0) begin n_fail++; $display("FAIL clr_no_done: got %0d want %0d", done_cnt, d0); end
    endtask

    task automatic test_ignored();
        logic [127:0] blk = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        logic [127:0] got;
        bit           to;
        bit           st;
        start_job(16'd1);
        pt_valid = 1'b1;
        pt_data  = blk[127:96];
        tick();
        pt_valid = 1'b0;
        tb_done  = 1'b1;
        tick();
        tb_done  = 1'b0;
        n_tests++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL ign_done_in_load_ready: got %b want 1", pt_ready); end
        n_tests++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL ign_done_in_load_valid: got %b want 0", ct_valid); end
        send_block(blk, 1, 0, to);
        n_tests++; if (core_blk_out !== blk) begin n_fail++; $display("FAIL ign_block: got %h want %h", core_blk_out, blk); end
        wait_ct_valid(to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL ign_drain_timeout: got %b want 0", to); end
        ctrl.start    = 1'b1;
        ctrl.n_blocks = 16'd5;
        tick();
        ctrl.start = 1'b0;
        n_tests++; if (ct_valid !== 1'b1) begin n_fail++; $display("FAIL ign_start_in_drain_valid: got %b want 1", ct_valid); end
        n_tests++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL ign_start_in_drain_ready: got %b want 0", pt_ready); end
        recv_block(0, got, to, st);
        n_tests++; if (got !== ~blk) begin n_fail++; $display("FAIL ign_words: got %h want %h", got, ~blk); end
        n_tests++; if (flags.done !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b want 1", flags.done); end
        n_tests++; if (flags.block_cnt !== 16'd1) begin n_fail++; $display("FAIL ign_block_cnt: got %0d want 1", flags.block_cnt); end
        tick();
        ctrl.enable   = 1'b0;
        ctrl.start    = 1'b1;
        ctrl.n_blocks = 16'd2;
        tick();
        ctrl.start = 1'b0;
        n_tests++; if (flags.busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_enable_busy: got %b want 0", flags.busy); end
        tick();
        n_tests++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL ign_no_enable_ready: got %b want 0", pt_ready); end
        ctrl.enable = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        logic [127:0] blk = 128'h00000001000000020000000300000004;
        bit           to;
        int           d0;
        d0 = done_cnt;
        start_job(16'd1);
        send_block(blk, 0, 0, to);
        tick();
        tick();
        n_tests++; if (flags.busy !== 1'b1) begin n_fail++; $display("FAIL rw_busy_in_wait: got %b want 1", flags.busy); end
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (flags !== '0) begin n_fail++; $display("FAIL rw_flags: got %h want 0", flags); end
        n_tests++; if (core_blk_out !== 128'h0) begin n_fail++; $display("FAIL rw_core_block: got %h want 0", core_blk_out); end
        n_tests++; if (ct_valid !== 1'b0 || pt_ready !== 1'b0 || core_start !== 1'b0) begin
            n_fail++; $display("FAIL rw_handshakes: got %b%b%b want 000", ct_valid, pt_ready, core_start);
        end
        #2 reset_n = 1'b1;
        tick();
        n_tests++; if (flags.busy !== 1'b0) begin n_fail++; $display("FAIL rw_idle_after: got %b want 0", flags.busy); end
        repeat (15) tick();
        n_tests++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL rw_no_output: got %b want 0", ct_valid); end
        n_tests++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rw_no_done: got %0d want %0d", done_cnt, d0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        ctrl     = '0;
        pt_valid = 1'b0;
        pt_data  = '0;
        ct_ready = 1'b0;
        tb_done  = 1'b0;
        test_reset();
        ctrl.enable = 1'b1;
        test_single_block();
        test_backpressure();
        test_zero_blocks();
        test_clear();
        test_ignored();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
